// File: rtl/sys_ctrl_if.sv
// Bus bundle between the UART-facing system controller and its register file,
// ALU and transmitter. master = controller side, slave = peripheral side.
interface sys_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int ADDR  = 4
);
   logic [WIDTH-1:0]   RX_P_DATA;
   logic               RX_D_VLD;
   logic               WrEn;
   logic               RdEn;
   logic [ADDR-1:0]    Address;
   logic [WIDTH-1:0]   WrData;
   logic [WIDTH-1:0]   RdData;
   logic               RdData_VLD;
   logic [3:0]         ALU_FUN;
   logic               ALU_EN;
   logic [2*WIDTH-1:0] ALU_OUT;
   logic               ALU_OUT_VLD;
   logic [WIDTH-1:0]   TX_P_DATA;
   logic               TX_D_VLD;
   logic               TX_BUSY;

   modport master (
      input  RX_P_DATA, RX_D_VLD, RdData, RdData_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
      output WrEn, RdEn, Address, WrData, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD, RdData, RdData_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
      input  WrEn, RdEn, Address, WrData, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD
   );
endinterface

// File: rtl/sys_ctrl.sv
// System controller: decodes UART command bytes into register-file writes/reads
// and ALU operations, and returns results to the UART transmitter.
module sys_ctrl #(
   parameter int WIDTH = 8,
   parameter int ADDR  = 4
) (
   input  logic       CLK,
   input  logic       RST,
   sys_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      WR_ADDR  = 4'd1,
      WR_DATA  = 4'd2,
      RD_ADDR  = 4'd3,
      RD_WAIT  = 4'd4,
      OP_A     = 4'd5,
      OP_B     = 4'd6,
      FUN      = 4'd7,
      ALU_WAIT = 4'd8,
      TX_B0    = 4'd9,
      TX_GAP   = 4'd10,
      TX_B1    = 4'd11
   } state_t;

   localparam logic [WIDTH-1:0] CMD_WR  = WIDTH'(8'hAA);
   localparam logic [WIDTH-1:0] CMD_RD  = WIDTH'(8'hBB);
   localparam logic [WIDTH-1:0] CMD_OP  = WIDTH'(8'hCC);
   localparam logic [WIDTH-1:0] CMD_FUN = WIDTH'(8'hDD);

   state_t             r_state;
   state_t             w_next_state;
   logic [ADDR-1:0]    r_addr,      w_addr;
   logic [WIDTH-1:0]   r_byte0,     w_byte0;
   logic [WIDTH-1:0]   r_byte1,     w_byte1;
   logic               r_single,    w_single;
   logic               r_seen_busy, w_seen_busy;
   logic               r_wren,      w_wren;
   logic               r_rden,      w_rden;
   logic [ADDR-1:0]    r_address,   w_address;
   logic [WIDTH-1:0]   r_wrdata,    w_wrdata;
   logic [3:0]         r_alu_fun,   w_alu_fun;
   logic               r_alu_en,    w_alu_en;
   logic [WIDTH-1:0]   r_tx_data,   w_tx_data;
   logic               r_tx_vld,    w_tx_vld;

   logic w_rx;
   logic w_busy;
   assign w_rx   = bus.RX_D_VLD;
   assign w_busy = bus.TX_BUSY;

   // State and all registered outputs/captures; reset abandons any command in flight.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_byte0     <= '0;
         r_byte1     <= '0;
         r_single    <= 1'b0;
         r_seen_busy <= 1'b0;
         r_wren      <= 1'b0;
         r_rden      <= 1'b0;
         r_address   <= '0;
         r_wrdata    <= '0;
         r_alu_fun   <= 4'd0;
         r_alu_en    <= 1'b0;
         r_tx_data   <= '0;
         r_tx_vld    <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_addr      <= w_addr;
         r_byte0     <= w_byte0;
         r_byte1     <= w_byte1;
         r_single    <= w_single;
         r_seen_busy <= w_seen_busy;
         r_wren      <= w_wren;
         r_rden      <= w_rden;
         r_address   <= w_address;
         r_wrdata    <= w_wrdata;
         r_alu_fun   <= w_alu_fun;
         r_alu_en    <= w_alu_en;
         r_tx_data   <= w_tx_data;
         r_tx_vld    <= w_tx_vld;
      end
   end

   // Next-state decode; command bytes are only recognised in IDLE.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_rx) begin
               if      (bus.RX_P_DATA == CMD_WR)  w_next_state = WR_ADDR;
               else if (bus.RX_P_DATA == CMD_RD)  w_next_state = RD_ADDR;
               else if (bus.RX_P_DATA == CMD_OP)  w_next_state = OP_A;
               else if (bus.RX_P_DATA == CMD_FUN) w_next_state = FUN;
               else                               w_next_state = IDLE;
            end else begin
               w_next_state = IDLE;
            end
         end
         WR_ADDR:  w_next_state = w_rx ? WR_DATA : WR_ADDR;
         WR_DATA:  w_next_state = w_rx ? IDLE    : WR_DATA;
         RD_ADDR:  w_next_state = w_rx ? RD_WAIT : RD_ADDR;
         RD_WAIT:  w_next_state = bus.RdData_VLD ? TX_B0 : RD_WAIT;
         OP_A:     w_next_state = w_rx ? OP_B    : OP_A;
         OP_B:     w_next_state = w_rx ? FUN     : OP_B;
         FUN:      w_next_state = w_rx ? ALU_WAIT : FUN;
         ALU_WAIT: w_next_state = bus.ALU_OUT_VLD ? TX_B0 : ALU_WAIT;
         TX_B0: begin
            if (!w_busy) w_next_state = r_single ? IDLE : TX_GAP;
            else         w_next_state = TX_B0;
         end
         // The transmitter must be seen busy with byte0 before byte1 may go.
         TX_GAP:   w_next_state = (r_seen_busy && !w_busy) ? TX_B1 : TX_GAP;
         TX_B1:    w_next_state = w_busy ? TX_B1 : IDLE;
         default:  w_next_state = IDLE;
      endcase
   end

   // Next values of outputs and captures; strobes default low, everything else holds.
   always_comb begin
      w_addr      = r_addr;
      w_byte0     = r_byte0;
      w_byte1     = r_byte1;
      w_single    = r_single;
      w_seen_busy = r_seen_busy;
      w_wren      = 1'b0;
      w_rden      = 1'b0;
      w_address   = r_address;
      w_wrdata    = r_wrdata;
      w_alu_fun   = r_alu_fun;
      w_alu_en    = 1'b0;
      w_tx_data   = r_tx_data;
      w_tx_vld    = 1'b0;
      case (r_state)
         WR_ADDR: begin
            w_addr = w_rx ? bus.RX_P_DATA[ADDR-1:0] : r_addr;
         end
         WR_DATA, OP_A, OP_B: begin
            if (w_rx) begin
               w_wren    = 1'b1;
               w_wrdata  = bus.RX_P_DATA;
               if (r_state == WR_DATA)   w_address = r_addr;
               else if (r_state == OP_A) w_address = '0;
               else                      w_address = ADDR'(1'b1);
            end else begin
               w_wren    = 1'b0;
            end
         end
         RD_ADDR: begin
            if (w_rx) begin
               w_rden    = 1'b1;
               w_address = bus.RX_P_DATA[ADDR-1:0];
            end else begin
               w_rden    = 1'b0;
            end
         end
         RD_WAIT: begin
            if (bus.RdData_VLD) begin
               w_byte0  = bus.RdData;
               w_single = 1'b1;
            end else begin
               w_single = r_single;
            end
         end
         FUN: begin
            if (w_rx) begin
               w_alu_fun = bus.RX_P_DATA[3:0];
               w_alu_en  = 1'b1;
            end else begin
               w_alu_en  = 1'b0;
            end
         end
         ALU_WAIT: begin
            w_alu_en = !bus.ALU_OUT_VLD;
            if (bus.ALU_OUT_VLD) begin
               w_byte0  = bus.ALU_OUT[WIDTH-1:0];
               w_byte1  = bus.ALU_OUT[2*WIDTH-1:WIDTH];
               w_single = 1'b0;
            end else begin
               w_single = r_single;
            end
         end
         TX_B0: begin
            if (!w_busy) begin
               w_tx_data   = r_byte0;
               w_tx_vld    = 1'b1;
               w_seen_busy = 1'b0;
            end else begin
               w_tx_vld    = 1'b0;
            end
         end
         TX_GAP: begin
            w_seen_busy = r_seen_busy | w_busy;
         end
         TX_B1: begin
            if (!w_busy) begin
               w_tx_data = r_byte1;
               w_tx_vld  = 1'b1;
            end else begin
               w_tx_vld  = 1'b0;
            end
         end
         default: begin
            w_tx_vld = 1'b0;
         end
      endcase
   end

   assign bus.WrEn      = r_wren;
   assign bus.RdEn      = r_rden;
   assign bus.Address   = r_address;
   assign bus.WrData    = r_wrdata;
   assign bus.ALU_FUN   = r_alu_fun;
   assign bus.ALU_EN    = r_alu_en;
   assign bus.TX_P_DATA = r_tx_data;
   assign bus.TX_D_VLD  = r_tx_vld;
endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl: command sequences with hand-computed expectations
// and a simple transmitter model that stays busy for a while after each byte.
module tb_sys_ctrl;
   localparam int WIDTH = 8;
   localparam int ADDR  = 4;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   sys_ctrl_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

   sys_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.master)
   );

   int checks   = 0;
   int failures = 0;

   // Transmitter model: busy for 8 cycles after each byte, or held busy by the bench.
   logic tx_hold = 1'b0;
   int   tx_cnt;
   assign bus.TX_BUSY = tx_hold | (tx_cnt != 0);

   always @(posedge CLK or negedge RST) begin
      if (!RST)              tx_cnt <= 0;
      else if (bus.TX_D_VLD) tx_cnt <= 8;
      else if (tx_cnt != 0)  tx_cnt <= tx_cnt - 1;
   end

   // Monitor: running totals of strobes, transmitted bytes and protocol violations.
   int         wren_cnt  = 0;
   int         rden_cnt  = 0;
   int         both_cnt  = 0;
   int         busy_viol = 0;
   logic [7:0] txq[$];

   always @(negedge CLK) begin
      if (bus.WrEn) wren_cnt <= wren_cnt + 1;
      if (bus.RdEn) rden_cnt <= rden_cnt + 1;
      if (bus.WrEn && bus.RdEn) both_cnt <= both_cnt + 1;
      if (bus.TX_D_VLD && bus.TX_BUSY) busy_viol <= busy_viol + 1;
      if (bus.TX_D_VLD) txq.push_back(bus.TX_P_DATA);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge CLK);
      bus.RX_P_DATA = b;
      bus.RX_D_VLD  = 1'b1;
      @(negedge CLK);
      bus.RX_D_VLD  = 1'b0;
   endtask

   int wb, rb, tb0;

   initial begin
      bus.RX_P_DATA   = 8'h00;
      bus.RX_D_VLD    = 1'b0;
      bus.RdData      = 8'h00;
      bus.RdData_VLD  = 1'b0;
      bus.ALU_OUT     = 16'h0000;
      bus.ALU_OUT_VLD = 1'b0;

      // Reset state
      tick(2);
      chk("rst_wren",   {31'd0, bus.WrEn},     32'd0);
      chk("rst_rden",   {31'd0, bus.RdEn},     32'd0);
      chk("rst_alu_en", {31'd0, bus.ALU_EN},   32'd0);
      chk("rst_tx_vld", {31'd0, bus.TX_D_VLD}, 32'd0);
      chk("rst_addr",   {28'd0, bus.Address},  32'd0);
      chk("rst_wrdata", {24'd0, bus.WrData},   32'd0);
      chk("rst_fun",    {28'd0, bus.ALU_FUN},  32'd0);
      chk("rst_txdata", {24'd0, bus.TX_P_DATA}, 32'd0);
      RST = 1'b1;
      tick(2);

      // Write: AA 05 3C
      #2; wb = wren_cnt; tb0 = txq.size();
      send(8'hAA); send(8'h05); send(8'h3C);
      chk("wr_wren",   {31'd0, bus.WrEn},    32'd1);
      chk("wr_addr",   {28'd0, bus.Address}, 32'd5);
      chk("wr_data",   {24'd0, bus.WrData},  32'h3C);
      tick(1);
      chk("wr_wren_off", {31'd0, bus.WrEn}, 32'd0);
      tick(5); #2;
      chk("wr_pulses", wren_cnt - wb,      32'd1);
      chk("wr_no_tx",  txq.size() - tb0,   32'd0);

      // Read: BB 02, stray AA while waiting, regfile returns 21
      wb = wren_cnt; rb = rden_cnt; tb0 = txq.size();
      send(8'hBB); send(8'h02);
      chk("rd_rden", {31'd0, bus.RdEn},    32'd1);
      chk("rd_addr", {28'd0, bus.Address}, 32'd2);
      tick(1);
      chk("rd_rden_off", {31'd0, bus.RdEn}, 32'd0);
      tick(3);
      send(8'hAA);
      tick(3);
      @(negedge CLK); bus.RdData = 8'h21; bus.RdData_VLD = 1'b1;
      @(negedge CLK); bus.RdData_VLD = 1'b0;
      tick(20); #2;
      chk("rd_pulses",   rden_cnt - rb,    32'd1);
      chk("rd_no_write", wren_cnt - wb,    32'd0);
      chk("rd_tx_count", txq.size() - tb0, 32'd1);
      if (txq.size() > tb0) chk("rd_tx_byte", {24'd0, txq[tb0]}, 32'h21);

      // ALU with operands: CC 0A 03 02, result 001E
      wb = wren_cnt; tb0 = txq.size();
      send(8'hCC); send(8'h0A);
      chk("opa_wren", {31'd0, bus.WrEn},    32'd1);
      chk("opa_addr", {28'd0, bus.Address}, 32'd0);
      chk("opa_data", {24'd0, bus.WrData},  32'h0A);
      send(8'h03);
      chk("opb_wren", {31'd0, bus.WrEn},    32'd1);
      chk("opb_addr", {28'd0, bus.Address}, 32'd1);
      chk("opb_data", {24'd0, bus.WrData},  32'h03);
      send(8'h02);
      chk("alu_fun",    {28'd0, bus.ALU_FUN}, 32'd2);
      chk("alu_en_on",  {31'd0, bus.ALU_EN},  32'd1);
      tick(5);
      chk("alu_en_hold", {31'd0, bus.ALU_EN}, 32'd1);
      @(negedge CLK); bus.ALU_OUT = 16'h001E; bus.ALU_OUT_VLD = 1'b1;
      @(negedge CLK); bus.ALU_OUT_VLD = 1'b0;
      chk("alu_en_off", {31'd0, bus.ALU_EN}, 32'd0);
      tick(40); #2;
      chk("alu_wr_pulses", wren_cnt - wb,    32'd2);
      chk("alu_tx_count",  txq.size() - tb0, 32'd2);
      if (txq.size() > tb0 + 1) begin
         chk("alu_tx_lsb", {24'd0, txq[tb0]},   32'h1E);
         chk("alu_tx_msb", {24'd0, txq[tb0+1]}, 32'h00);
      end

      // ALU without operands, transmitter held busy for 20 cycles
      tx_hold = 1'b1;
      wb = wren_cnt; tb0 = txq.size();
      send(8'hDD); send(8'h00);
      chk("fun_only_fun", {28'd0, bus.ALU_FUN}, 32'd0);
      chk("fun_only_en",  {31'd0, bus.ALU_EN},  32'd1);
      @(negedge CLK); bus.ALU_OUT = 16'h1234; bus.ALU_OUT_VLD = 1'b1;
      @(negedge CLK); bus.ALU_OUT_VLD = 1'b0;
      tick(20); #2;
      chk("busy_hold_no_tx", txq.size() - tb0, 32'd0);
      tx_hold = 1'b0;
      tick(40); #2;
      chk("fun_only_tx_count", txq.size() - tb0, 32'd2);
      chk("fun_only_no_write", wren_cnt - wb,    32'd0);
      if (txq.size() > tb0 + 1) begin
         chk("fun_only_lsb", {24'd0, txq[tb0]},   32'h34);
         chk("fun_only_msb", {24'd0, txq[tb0+1]}, 32'h12);
      end

      // Unknown byte in IDLE
      wb = wren_cnt; rb = rden_cnt; tb0 = txq.size();
      send(8'h55);
      tick(5); #2;
      chk("junk_no_wr", wren_cnt - wb,    32'd0);
      chk("junk_no_rd", rden_cnt - rb,    32'd0);
      chk("junk_no_tx", txq.size() - tb0, 32'd0);
      chk("junk_no_en", {31'd0, bus.ALU_EN}, 32'd0);

      // Command codes as address/data: AA BB AA -> write AA to address B
      send(8'hAA); send(8'hBB); send(8'hAA);
      chk("cmd_as_data_wren", {31'd0, bus.WrEn},    32'd1);
      chk("cmd_as_data_addr", {28'd0, bus.Address}, 32'hB);
      chk("cmd_as_data_data", {24'd0, bus.WrData},  32'hAA);

      // Reset mid-command: AA 05, reset, then 3C must not write
      tick(2); #2;
      wb = wren_cnt;
      send(8'hAA); send(8'h05);
      @(negedge CLK); RST = 1'b0;
      #1;
      chk("midrst_wren",   {31'd0, bus.WrEn},    32'd0);
      chk("midrst_addr",   {28'd0, bus.Address}, 32'd0);
      chk("midrst_wrdata", {24'd0, bus.WrData},  32'd0);
      tick(2); RST = 1'b1;
      tick(1);
      send(8'h3C);
      tick(5); #2;
      chk("midrst_no_wr", wren_cnt - wb, 32'd0);

      chk("wr_rd_exclusive", both_cnt,  32'd0);
      chk("tx_while_busy",   busy_viol, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sys_ctrl.md
SYS_CTRL -- requirements
Module: sys_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data byte width.
REQ-002 Parameter ADDR, default 4: register-file address width.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 RX_P_DATA  input  WIDTH  received UART byte.
REQ-006 RX_D_VLD  input  1  one-cycle pulse; RX_P_DATA valid.
REQ-007 WrEn  output  1  register-file write strobe.
REQ-008 RdEn  output  1  register-file read strobe.
REQ-009 Address  output  ADDR  register-file address.
REQ-010 WrData  output  WIDTH  register-file write data.
REQ-011 RdData  input  WIDTH  register-file read data.
REQ-012 RdData_VLD  input  1  RdData valid.
REQ-013 ALU_FUN  output  4  ALU function select.
REQ-014 ALU_EN  output  1  ALU enable.
REQ-015 ALU_OUT  input  2*WIDTH  ALU result.
REQ-016 ALU_OUT_VLD  input  1  ALU_OUT valid.
REQ-017 TX_P_DATA  output  WIDTH  byte to UART transmitter.
REQ-018 TX_D_VLD  output  1  one-cycle pulse; TX_P_DATA valid.
REQ-019 TX_BUSY  input  1  transmitter busy.

Function
REQ-020 All outputs SHALL be registered; WrEn and RdEn SHALL never be high in the same cycle.
REQ-021 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX_B0, TX_GAP, TX_B1.
REQ-022 IDLE, RX_D_VLD with byte 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; 0xCC -> OP_A; 0xDD -> FUN; any other byte -> discarded, stay IDLE.
REQ-023 WR_ADDR: on RX_D_VLD, latch RX_P_DATA[ADDR-1:0] as address -> WR_DATA.
REQ-024 WR_DATA: on RX_D_VLD, drive Address=latched address, WrData=RX_P_DATA, WrEn=1 for exactly the next cycle -> IDLE.
REQ-025 RD_ADDR: on RX_D_VLD, drive Address=RX_P_DATA[ADDR-1:0], RdEn=1 for exactly the next cycle -> RD_WAIT.
REQ-026 RD_WAIT: on RdData_VLD, capture RdData as byte0 -> TX_B0 with single-byte flag set; no timeout.
REQ-027 OP_A: on RX_D_VLD, write RX_P_DATA to address 0 (one-cycle WrEn) -> OP_B; OP_B: same to address 1 -> FUN.
REQ-028 FUN: on RX_D_VLD, latch ALU_FUN=RX_P_DATA[3:0] -> ALU_WAIT.
REQ-029 ALU_WAIT: ALU_EN=1 held until ALU_OUT_VLD sampled high; that cycle capture ALU_OUT, byte0=ALU_OUT[WIDTH-1:0], byte1=ALU_OUT[2*WIDTH-1:WIDTH], deassert ALU_EN next cycle -> TX_B0 with single-byte flag clear.
REQ-030 TX_B0: when TX_BUSY=0, drive TX_P_DATA=byte0 with TX_D_VLD=1 for one cycle; then -> IDLE if single-byte flag set, else -> TX_GAP.
REQ-031 TX_GAP: wait for TX_BUSY=1 then TX_BUSY=0 -> TX_B1; transmitter SHALL raise TX_BUSY within 2 cycles of TX_D_VLD.
REQ-032 TX_B1: when TX_BUSY=0, drive TX_P_DATA=byte1, TX_D_VLD=1 one cycle -> IDLE.
REQ-033 RX_D_VLD in RD_WAIT, ALU_WAIT, TX_B0, TX_GAP, TX_B1 SHALL be ignored (byte dropped, no state change).
REQ-034 Command bytes are only decoded in IDLE; 0xAA etc. arriving as operand/address/data SHALL be treated as data.

Reset
REQ-035 RST low SHALL immediately force state IDLE, WrEn=0, RdEn=0, ALU_EN=0, TX_D_VLD=0, Address=0, WrData=0, ALU_FUN=0, TX_P_DATA=0, captured bytes and flags cleared.
REQ-036 Reset mid-command SHALL abandon the command; no strobe SHALL be issued after RST deasserts until a new command completes.

Verification
REQ-037 Write: RX 0xAA,0x05,0x3C -> one cycle WrEn=1, Address=5, WrData=0x3C; no TX_D_VLD.
REQ-038 Read: RX 0xBB,0x02; regfile returns 0x21 -> one RdEn pulse at Address=2, then one TX_D_VLD with TX_P_DATA=0x21.
REQ-039 ALU with operands: RX 0xCC,0x0A,0x03,0x02; ALU_OUT=0x001E -> WrEn at addresses 0 (0x0A) and 1 (0x03), ALU_FUN=2, ALU_EN high until valid, TX 0x1E then 0x00 gated by TX_BUSY.
REQ-040 ALU without operands: RX 0xDD,0x00 with TX_BUSY held high 20 cycles -> no TX_D_VLD until TX_BUSY=0, then LSB, MSB.
REQ-041 Robustness: RX 0x55 in IDLE -> no strobes; RX byte during RD_WAIT -> dropped.
REQ-042 Reset mid-command: RX 0xAA,0x05, assert RST, release, RX 0x3C -> no WrEn.
